// File: rtl/int_controller_if.sv
// Bus bundle between the interrupt sequencer and the CPU front end.
// The master side drives requests and config; the slave is the controller.
interface int_controller_if #(
  parameter int NUM_IRQ = 8,
  parameter int ADDR_W  = 32
);
  logic [NUM_IRQ-1:0] irq;
  logic               cfg_mask_we;
  logic [NUM_IRQ-1:0] cfg_mask_wdata;
  logic               cfg_ie_we;
  logic               cfg_ie_wdata;
  logic [ADDR_W-1:0]  pc_in;
  logic               stall;
  logic               eret;
  logic               int_en1;
  logic               ret_valid;
  logic [ADDR_W-1:0]  epc;
  logic [3:0]         cause;
  logic               int_active;
  logic [NUM_IRQ-1:0] pending;
  logic               ie;

  modport master (
    output irq, cfg_mask_we, cfg_mask_wdata,
    output cfg_ie_we, cfg_ie_wdata,
    output pc_in, stall, eret,
    input  int_en1, ret_valid, epc, cause,
    input  int_active, pending, ie
  );

  modport slave (
    input  irq, cfg_mask_we, cfg_mask_wdata,
    input  cfg_ie_we, cfg_ie_wdata,
    input  pc_in, stall, eret,
    output int_en1, ret_valid, epc, cause,
    output int_active, pending, ie
  );
endinterface

// File: rtl/int_controller.sv
// Interrupt sequencer: edge capture, masking, fixed priority,
// one-cycle vector redirect, EPC/cause save and eret return.
module int_controller #(
  parameter int NUM_IRQ = 8,
  parameter int ADDR_W  = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  int_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    SERVICE,
    RETURN
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               ie_q;
  logic [ADDR_W-1:0]  epc_q;
  logic [3:0]         cause_q;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [3:0]         idx;
  logic               found;
  logic               take;

  assign eligible = pending_q & mask_q;
  assign rise     = bus.irq & ~irq_q;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!found && eligible[i]) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
  end

  assign take = (state_q == IDLE) & ie_q & found & ~bus.stall;
  assign clr  = take ? (NUM_IRQ'(1) << idx) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = TAKE;
      TAKE:    state_d = SERVICE;
      SERVICE: if (bus.eret) state_d = RETURN;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ie_q      <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= bus.irq;
      // a fresh edge on the bit being cleared keeps it pending
      pending_q <= (pending_q & ~clr) | rise;
      if (bus.cfg_mask_we)
        mask_q <= bus.cfg_mask_wdata;
      if (take)
        ie_q <= 1'b0;
      else if (state_q == RETURN)
        ie_q <= 1'b1;
      else if (bus.cfg_ie_we &&
               (state_q == IDLE || state_q == SERVICE))
        ie_q <= bus.cfg_ie_wdata;
      if (take) begin
        epc_q   <= bus.pc_in;
        cause_q <= idx;
      end
    end
  end

  assign bus.int_en1    = (state_q == TAKE);
  assign bus.ret_valid  = (state_q == RETURN);
  assign bus.int_active = (state_q != IDLE);
  assign bus.epc        = epc_q;
  assign bus.cause      = cause_q;
  assign bus.pending    = pending_q;
  assign bus.ie         = ie_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with a cycle model of the
// sequencer rules and hand-computed spot checks.
module tb_int_controller;
  localparam int N = 8;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  int_controller_if #(.NUM_IRQ(N), .ADDR_W(W)) bus();

  int_controller #(.NUM_IRQ(N), .ADDR_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 vector cycle, 2 in handler, 3 returning
  int           m_phase = 0;
  logic [N-1:0] m_irq_q = '0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_mask  = '0;
  logic         m_ie    = 1'b0;
  logic [W-1:0] m_epc   = '0;
  logic [3:0]   m_cause = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_irq_q = '0; m_pend = '0; m_mask = '0;
      m_ie = 1'b0; m_epc = '0; m_cause = '0;
    end else begin
      logic [N-1:0] elig;
      logic [N-1:0] np;
      logic         nie;
      int           win;
      int           nphase;
      elig = m_pend & m_mask;
      win = -1;
      for (int i = N - 1; i >= 0; i--)
        if (elig[i]) win = i;
      np = m_pend;
      nie = m_ie;
      nphase = m_phase;
      if ((m_phase == 0 || m_phase == 2) && bus.cfg_ie_we)
        nie = bus.cfg_ie_wdata;
      case (m_phase)
        0: if (m_ie && win >= 0 && !bus.stall) begin
             nphase = 1;
             np[win] = 1'b0;
             nie = 1'b0;
             m_epc = bus.pc_in;
             m_cause = 4'(win);
           end
        1: nphase = 2;
        2: if (bus.eret) nphase = 3;
        default: begin nphase = 0; nie = 1'b1; end
      endcase
      m_pend  = np | (bus.irq & ~m_irq_q);
      m_irq_q = bus.irq;
      if (bus.cfg_mask_we) m_mask = bus.cfg_mask_wdata;
      m_ie    = nie;
      m_phase = nphase;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_int_en1", W'(bus.int_en1), W'(m_phase == 1));
      chk("m_ret_valid", W'(bus.ret_valid), W'(m_phase == 3));
      chk("m_int_active", W'(bus.int_active), W'(m_phase != 0));
      chk("m_epc", bus.epc, m_epc);
      chk("m_cause", W'(bus.cause), W'(m_cause));
      chk("m_pending", W'(bus.pending), W'(m_pend));
      chk("m_ie", W'(bus.ie), W'(m_ie));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_int_en(input int max);
    int k;
    k = 0;
    while (!bus.int_en1 && k < max) begin
      tick();
      k++;
    end
    if (!bus.int_en1) begin
      checks++;
      errors++;
      $display("FAIL wait_int_en: got 0 expected 1 within %0d", max);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.irq = '0; bus.cfg_mask_we = 0; bus.cfg_mask_wdata = '0;
    bus.cfg_ie_we = 0; bus.cfg_ie_wdata = 0; bus.pc_in = '0;
    bus.stall = 0; bus.eret = 0;
    tick(2);
    chk("rst_pending", W'(bus.pending), 0);
    chk("rst_ie", W'(bus.ie), 0);
    reset_n = 1'b1;
    tick();

    // test 1: single request on line 3
    bus.cfg_ie_we = 1; bus.cfg_ie_wdata = 1;
    bus.cfg_mask_we = 1; bus.cfg_mask_wdata = 8'hFF;
    bus.pc_in = 32'h100;
    tick();
    bus.cfg_ie_we = 0; bus.cfg_mask_we = 0;
    bus.irq = 8'h08;
    tick();
    bus.irq = 8'h00;
    chk("t1_pend", W'(bus.pending), 32'h08);
    chk("t1_no_en", W'(bus.int_en1), 0);
    tick();
    chk("t1_en", W'(bus.int_en1), 1);
    chk("t1_epc", bus.epc, 32'h100);
    chk("t1_cause", W'(bus.cause), 3);
    chk("t1_ie", W'(bus.ie), 0);
    chk("t1_pclr", W'(bus.pending), 0);
    bus.cfg_ie_we = 1; bus.cfg_ie_wdata = 1;
    tick();
    bus.cfg_ie_we = 0;
    chk("t1_ie_take_ign", W'(bus.ie), 0);
    chk("t1_en_once", W'(bus.int_en1), 0);
    bus.eret = 1;
    tick();
    bus.eret = 0;
    chk("t1_ret", W'(bus.ret_valid), 1);
    tick();
    chk("t1_ie_back", W'(bus.ie), 1);
    chk("t1_idle", W'(bus.int_active), 0);

    // test 2: simultaneous 5 and 2, lower index first
    bus.pc_in = 32'h180;
    bus.irq = 8'h24;
    tick();
    bus.irq = 8'h00;
    chk("t2_pend", W'(bus.pending), 32'h24);
    tick();
    chk("t2_cause_a", W'(bus.cause), 2);
    chk("t2_pend_a", W'(bus.pending), 32'h20);
    tick();
    bus.eret = 1;
    tick();
    bus.eret = 0;
    chk("t2_ret", W'(bus.ret_valid), 1);
    tick();
    chk("t2_gap", W'(bus.int_en1), 0);
    tick();
    chk("t2_en_b", W'(bus.int_en1), 1);
    chk("t2_cause_b", W'(bus.cause), 5);
    tick();
    bus.eret = 1;
    tick();
    bus.eret = 0;
    tick(2);

    // test 3: masked request waits for unmask
    bus.cfg_mask_we = 1; bus.cfg_mask_wdata = 8'h00;
    tick();
    bus.cfg_mask_we = 0;
    bus.irq = 8'h02;
    tick();
    bus.irq = 8'h00;
    tick(3);
    chk("t3_no_en", W'(bus.int_active), 0);
    chk("t3_held", W'(bus.pending), 32'h02);
    bus.cfg_mask_we = 1; bus.cfg_mask_wdata = 8'h02;
    tick();
    bus.cfg_mask_we = 0;
    tick();
    chk("t3_en", W'(bus.int_en1), 1);
    chk("t3_cause", W'(bus.cause), 1);
    tick();
    bus.eret = 1;
    tick();
    bus.eret = 0;
    tick();
    bus.cfg_mask_we = 1; bus.cfg_mask_wdata = 8'hFF;
    tick();
    bus.cfg_mask_we = 0;

    // test 4: stall defers the take
    bus.stall = 1;
    bus.pc_in = 32'h200;
    bus.irq = 8'h10;
    tick();
    bus.irq = 8'h00;
    tick(3);
    chk("t4_stalled", W'(bus.int_active), 0);
    bus.stall = 0;
    bus.pc_in = 32'h240;
    tick();
    chk("t4_en", W'(bus.int_en1), 1);
    chk("t4_epc", bus.epc, 32'h240);
    chk("t4_cause", W'(bus.cause), 4);
    tick();

    // test 5: request during handler, then back-to-back
    bus.irq = 8'h01;
    tick();
    bus.irq = 8'h00;
    chk("t5_pend", W'(bus.pending), 32'h01);
    bus.eret = 1;
    tick();
    bus.eret = 0;
    chk("t5_ret", W'(bus.ret_valid), 1);
    chk("t5_epc", bus.epc, 32'h240);
    tick();
    chk("t5_ie", W'(bus.ie), 1);
    wait_int_en(3);
    chk("t5_cause", W'(bus.cause), 0);
    tick();

    // test 6: asynchronous reset inside the handler
    chk("t6_active", W'(bus.int_active), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_active0", W'(bus.int_active), 0);
    chk("t6_en0", W'(bus.int_en1), 0);
    chk("t6_ret0", W'(bus.ret_valid), 0);
    chk("t6_ie0", W'(bus.ie), 0);
    chk("t6_pend0", W'(bus.pending), 0);
    chk("t6_epc0", bus.epc, 0);
    tick();
    reset_n = 1'b1;
    tick(2);
    chk("t6_idle", W'(bus.int_active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
